ecc_secded_pipe: RTL and testbench

- Parametrised, pipelined SECDED (Hsiao/extended-Hamming) encoder plus decoder, with valid/ready handshakes on both paths.
- Sits between FIFO/RAM write/read ports and the surrounding datapath.
- Adds features beyond a combinational ECC block: registered encode, 2-stage decode, single-shot error injection, saturating error counters and first-uncorrectable capture.

---
 rtl/ecc_pkg.sv | 28 ++
 rtl/ecc_parity_gen.sv | 26 ++
 rtl/ecc_secded_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_ecc_secded_pipe.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared SECDED definitions: H-matrix column generator, error classes and
// the width rule that every instance must satisfy.
package ecc_pkg;

    typedef enum logic [1:0] {ERR_NONE, ERR_DATA_CE, ERR_CHK_CE, ERR_UE} err_class_t;

    // Column i: i-th integer >= 3 that is not a power of two, MSB set when
    // needed so every data column has odd weight.
    function automatic logic [31:0] ecc_col(input int i, input int r);
        logic [31:0] low;
        int          cnt;
        low = '0;
        cnt = 0;
        for (int n = 3; n < (1 << (r - 1)); n++) begin
            if ((n & (n - 1)) != 0) begin
                if (cnt == i) low = 32'(n);
                cnt++;
            end
        end
        if (($countones(low) % 2) == 0) low[r-1] = 1'b1;
        return low;
    endfunction

    function automatic bit ecc_width_ok(input int d, input int r);
        return ((1 << (r - 1)) - r) >= d;
    endfunction

endpackage

// File: rtl/ecc_parity_gen.sv
// Combinational SECDED check-bit generator: p[k] = XOR of data bits whose
// H column has bit k set.
module ecc_parity_gen
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH   = 26,
    parameter int PARITY_WIDTH = 6
) (
    input  logic [DATA_WIDTH-1:0]   i_data,
    output logic [PARITY_WIDTH-1:0] o_parity
);

    logic [DATA_WIDTH-1:0][PARITY_WIDTH-1:0] w_col;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_col
        localparam logic [31:0] COL = ecc_col(i, PARITY_WIDTH);
        assign w_col[i] = COL[PARITY_WIDTH-1:0];
    end

    always_comb begin
        o_parity = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            if (i_data[i]) o_parity = o_parity ^ w_col[i];
    end

endmodule

// File: rtl/ecc_secded_pipe.sv
// Pipelined SECDED encoder (1 stage, with error injection) and decoder
// (syndrome stage + correct stage), plus error counters and first-UE capture.
module ecc_secded_pipe
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH   = 26,
    parameter int PARITY_WIDTH = 6,
    parameter int TAG_W        = 8,
    parameter int CNT_W        = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_enc_valid,
    output logic                               o_enc_ready,
    input  logic [DATA_WIDTH-1:0]              i_enc_data,
    output logic                               o_enc_out_valid,
    input  logic                               i_enc_out_ready,
    output logic [DATA_WIDTH-1:0]              o_enc_out_data,
    output logic [PARITY_WIDTH-1:0]            o_enc_out_parity,
    input  logic                               i_inject_arm,
    input  logic [DATA_WIDTH+PARITY_WIDTH-1:0] i_inject_mask,
    input  logic                               i_dec_valid,
    output logic                               o_dec_ready,
    input  logic [DATA_WIDTH-1:0]              i_dec_data,
    input  logic [PARITY_WIDTH-1:0]            i_dec_parity,
    input  logic [TAG_W-1:0]                   i_dec_tag,
    output logic                               o_dec_out_valid,
    input  logic                               i_dec_out_ready,
    output logic [DATA_WIDTH-1:0]              o_dec_out_data,
    output logic [TAG_W-1:0]                   o_dec_out_tag,
    output logic                               o_dec_out_sbit,
    output logic                               o_dec_out_dbit,
    input  logic                               i_bypass,
    input  logic                               i_cnt_clr,
    output logic [CNT_W-1:0]                   o_sbit_cnt,
    output logic [CNT_W-1:0]                   o_dbit_cnt,
    output logic                               o_first_dbit_vld,
    output logic [TAG_W-1:0]                   o_first_dbit_tag
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = PARITY_WIDTH;

    if (!ecc_width_ok(DATA_WIDTH, PARITY_WIDTH)) begin : g_width_chk
        $fatal(1, "ecc_secded_pipe: PARITY_WIDTH too small for DATA_WIDTH");
    end

    logic [DW-1:0][PW-1:0] w_col;
    for (genvar i = 0; i < DW; i++) begin : g_col
        localparam logic [31:0] COL = ecc_col(i, PW);
        assign w_col[i] = COL[PW-1:0];
    end

    // ---------------- encode ----------------
    logic              r_enc_vld, r_armed;
    logic [DW-1:0]     r_enc_data;
    logic [PW-1:0]     r_enc_par, w_enc_par;
    logic [DW+PW-1:0]  r_mask, w_inj;
    logic              w_enc_acc;

    ecc_parity_gen #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW)) u_enc_par (
        .i_data   (i_enc_data),
        .o_parity (w_enc_par)
    );

    assign o_enc_ready = !r_enc_vld || i_enc_out_ready;
    assign w_enc_acc   = i_enc_valid && o_enc_ready;
    assign w_inj       = r_armed ? r_mask : '0;

    // A new arm wins over the disarm of a coincident accept: it targets the next word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enc_vld  <= 1'b0;
            r_enc_data <= '0;
            r_enc_par  <= '0;
            r_armed    <= 1'b0;
            r_mask     <= '0;
        end else begin
            if (w_enc_acc) begin
                r_enc_vld  <= 1'b1;
                r_enc_data <= i_enc_data ^ w_inj[DW+PW-1:PW];
                r_enc_par  <= w_enc_par ^ w_inj[PW-1:0];
            end else if (i_enc_out_ready) begin
                r_enc_vld  <= 1'b0;
            end
            if (i_inject_arm) begin
                r_armed <= 1'b1;
                r_mask  <= i_inject_mask;
            end else if (w_enc_acc) begin
                r_armed <= 1'b0;
            end
        end
    end

    assign o_enc_out_valid  = r_enc_vld;
    assign o_enc_out_data   = r_enc_data;
    assign o_enc_out_parity = r_enc_par;

    // ---------------- decode ----------------
    logic [2:1]       r_vld_pipe;
    logic [DW-1:0]    r_s1_data, r_s2_data, w_flip, w_s2_data;
    logic [TAG_W-1:0] r_s1_tag, r_s2_tag;
    logic [PW-1:0]    r_s1_syn, w_dec_par;
    logic             r_s2_sbit, r_s2_dbit, w_s2_sbit, w_s2_dbit;
    logic             w_s2_rdy, w_s1_acc, w_s2_acc;
    err_class_t       w_class;

    ecc_parity_gen #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW)) u_dec_par (
        .i_data   (i_dec_data),
        .o_parity (w_dec_par)
    );

    assign w_s2_rdy    = !r_vld_pipe[2] || i_dec_out_ready;
    assign o_dec_ready = !r_vld_pipe[1] || w_s2_rdy;
    assign w_s1_acc    = i_dec_valid && o_dec_ready;
    assign w_s2_acc    = r_vld_pipe[1] && w_s2_rdy;

    always_comb begin
        w_class = ERR_NONE;
        w_flip  = '0;
        if (r_s1_syn != '0) begin
            w_class = $onehot(r_s1_syn) ? ERR_CHK_CE : ERR_UE;
            for (int i = 0; i < DW; i++) begin
                if (r_s1_syn == w_col[i]) begin
                    w_class   = ERR_DATA_CE;
                    w_flip[i] = 1'b1;
                end
            end
        end
    end

    assign w_s2_data = i_bypass ? r_s1_data : (r_s1_data ^ w_flip);
    assign w_s2_sbit = !i_bypass && (w_class == ERR_DATA_CE || w_class == ERR_CHK_CE);
    assign w_s2_dbit = !i_bypass && (w_class == ERR_UE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_s1_data  <= '0;
            r_s1_tag   <= '0;
            r_s1_syn   <= '0;
            r_s2_data  <= '0;
            r_s2_tag   <= '0;
            r_s2_sbit  <= 1'b0;
            r_s2_dbit  <= 1'b0;
        end else begin
            if (w_s1_acc) begin
                r_vld_pipe[1] <= 1'b1;
                r_s1_data     <= i_dec_data;
                r_s1_tag      <= i_dec_tag;
                r_s1_syn      <= i_dec_parity ^ w_dec_par;
            end else if (w_s2_rdy) begin
                r_vld_pipe[1] <= 1'b0;
            end
            if (w_s2_acc) begin
                r_vld_pipe[2] <= 1'b1;
                r_s2_data     <= w_s2_data;
                r_s2_tag      <= r_s1_tag;
                r_s2_sbit     <= w_s2_sbit;
                r_s2_dbit     <= w_s2_dbit;
            end else if (i_dec_out_ready) begin
                r_vld_pipe[2] <= 1'b0;
            end
        end
    end

    assign o_dec_out_valid = r_vld_pipe[2];
    assign o_dec_out_data  = r_s2_data;
    assign o_dec_out_tag   = r_s2_tag;
    assign o_dec_out_sbit  = r_s2_sbit;
    assign o_dec_out_dbit  = r_s2_dbit;

    // ---------------- counters / capture ----------------
    logic [CNT_W-1:0] r_sbit_cnt, r_dbit_cnt;
    logic             r_first_vld;
    logic [TAG_W-1:0] r_first_tag;
    logic             w_sev, w_dev;

    assign w_sev = r_vld_pipe[2] && i_dec_out_ready && r_s2_sbit;
    assign w_dev = r_vld_pipe[2] && i_dec_out_ready && r_s2_dbit;

    // Events are counted at output transfer so stalled words count exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sbit_cnt  <= '0;
            r_dbit_cnt  <= '0;
            r_first_vld <= 1'b0;
            r_first_tag <= '0;
        end else if (i_cnt_clr) begin
            r_sbit_cnt  <= {{(CNT_W-1){1'b0}}, w_sev};
            r_dbit_cnt  <= {{(CNT_W-1){1'b0}}, w_dev};
            r_first_vld <= w_dev;
            r_first_tag <= w_dev ? r_s2_tag : '0;
        end else begin
            if (w_sev && (r_sbit_cnt != '1)) r_sbit_cnt <= r_sbit_cnt + 1'b1;
            if (w_dev && (r_dbit_cnt != '1)) r_dbit_cnt <= r_dbit_cnt + 1'b1;
            if (w_dev && !r_first_vld) begin
                r_first_vld <= 1'b1;
                r_first_tag <= r_s2_tag;
            end
        end
    end

    assign o_sbit_cnt       = r_sbit_cnt;
    assign o_dbit_cnt       = r_dbit_cnt;
    assign o_first_dbit_vld = r_first_vld;
    assign o_first_dbit_tag = r_first_tag;

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Self-checking bench for ecc_secded_pipe: directed scenarios plus randomized
// streams checked against a word-level SECDED model (CNT_W=2 to reach saturation).
module tb_ecc_secded_pipe;

    localparam int DW = 26;
    localparam int PW = 6;
    localparam int TW = 8;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic enc_valid, enc_ready, enc_out_valid, enc_out_ready;
    logic [DW-1:0] enc_data, enc_out_data;
    logic [PW-1:0] enc_out_parity;
    logic inject_arm;
    logic [DW+PW-1:0] inject_mask;
    logic dec_valid, dec_ready, dec_out_valid, dec_out_ready;
    logic [DW-1:0] dec_data, dec_out_data;
    logic [PW-1:0] dec_parity;
    logic [TW-1:0] dec_tag, dec_out_tag, first_dbit_tag;
    logic dec_out_sbit, dec_out_dbit, bypass, cnt_clr, first_dbit_vld;
    logic [CW-1:0] sbit_cnt, dbit_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic [PW-1:0] p;
        logic [TW-1:0] t;
        logic [DW-1:0] ed;
        logic          es;
        logic          eb;
    } word_t;

    word_t in_q[$];
    word_t exp_q[$];
    word_t obs_q[$];
    logic [PW-1:0] col [DW];

    ecc_secded_pipe #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .TAG_W(TW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_enc_valid(enc_valid), .o_enc_ready(enc_ready), .i_enc_data(enc_data),
        .o_enc_out_valid(enc_out_valid), .i_enc_out_ready(enc_out_ready),
        .o_enc_out_data(enc_out_data), .o_enc_out_parity(enc_out_parity),
        .i_inject_arm(inject_arm), .i_inject_mask(inject_mask),
        .i_dec_valid(dec_valid), .o_dec_ready(dec_ready), .i_dec_data(dec_data),
        .i_dec_parity(dec_parity), .i_dec_tag(dec_tag),
        .o_dec_out_valid(dec_out_valid), .i_dec_out_ready(dec_out_ready),
        .o_dec_out_data(dec_out_data), .o_dec_out_tag(dec_out_tag),
        .o_dec_out_sbit(dec_out_sbit), .o_dec_out_dbit(dec_out_dbit),
        .i_bypass(bypass), .i_cnt_clr(cnt_clr),
        .o_sbit_cnt(sbit_cnt), .o_dbit_cnt(dbit_cnt),
        .o_first_dbit_vld(first_dbit_vld), .o_first_dbit_tag(first_dbit_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog");
    end

    // H columns straight from the rule: ascending non-powers-of-two >= 3, odd weight.
    task automatic build_cols;
        int n = 3;
        int idx = 0;
        while (idx < DW) begin
            if ((n & (n - 1)) != 0) begin
                col[idx] = PW'(n);
                if (($countones(n) % 2) == 0) col[idx][PW-1] = 1'b1;
                idx++;
            end
            n++;
        end
    endtask

    function automatic logic [PW-1:0] tb_parity(input logic [DW-1:0] d);
        logic [PW-1:0] p = '0;
        for (int i = 0; i < DW; i++) if (d[i]) p = p ^ col[i];
        return p;
    endfunction

    // kind: 0 clean, 1 data-bit flip, 2 check-bit flip, 3 two distinct flips.
    function automatic word_t make_word(input int kind, input bit byp);
        word_t w;
        logic [DW+PW-1:0] cw;
        int a, b;
        w.d = DW'($urandom);
        w.t = TW'($urandom);
        cw = {w.d, tb_parity(w.d)};
        w.ed = w.d; w.es = 1'b0; w.eb = 1'b0;
        case (kind)
            1: begin a = $urandom_range(DW+PW-1, PW); cw[a] = ~cw[a]; w.es = 1'b1; end
            2: begin a = $urandom_range(PW-1, 0);     cw[a] = ~cw[a]; w.es = 1'b1; end
            3: begin
                a = $urandom_range(DW+PW-1, 0);
                do b = $urandom_range(DW+PW-1, 0); while (b == a);
                cw[a] = ~cw[a]; cw[b] = ~cw[b];
                w.eb = 1'b1;
                w.ed = cw[DW+PW-1:PW];
            end
            default: ;
        endcase
        w.d = cw[DW+PW-1:PW];
        w.p = cw[PW-1:0];
        if (byp) begin w.ed = w.d; w.es = 1'b0; w.eb = 1'b0; end
        return w;
    endfunction

    // Single decode word through an empty pipe; returns with the result on the outputs.
    task automatic dec_one(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic [TW-1:0] t);
        @(negedge clk);
        dec_valid = 1'b1; dec_data = d; dec_parity = p; dec_tag = t;
        @(posedge clk);
        @(negedge clk);
        dec_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_clr;
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
    endtask

    // Streams in_q into the decoder; mode 0 always ready, 1 ready low in cycles 3-8, 2 random.
    task automatic stream(input int mode, output int stalls, output bit tmo);
        int cyc = 0;
        int nexp = in_q.size();
        bit pend = 1'b0;
        word_t cur = '{default: '0};
        word_t o = '{default: '0};
        stalls = 0; tmo = 1'b0;
        obs_q.delete();
        while (obs_q.size() < nexp) begin
            @(negedge clk);
            if (!pend && in_q.size() > 0 && (mode != 2 || $urandom_range(3, 0) != 0)) begin
                cur = in_q.pop_front();
                pend = 1'b1;
            end
            dec_valid = pend; dec_data = cur.d; dec_parity = cur.p; dec_tag = cur.t;
            case (mode)
                1: dec_out_ready = !(cyc >= 3 && cyc <= 8);
                2: dec_out_ready = ($urandom_range(2, 0) != 0);
                default: dec_out_ready = 1'b1;
            endcase
            #1;
            if (dec_valid && !dec_ready) stalls++;
            if (dec_valid && dec_ready) pend = 1'b0;
            if (dec_out_valid && dec_out_ready) begin
                o.ed = dec_out_data; o.t = dec_out_tag; o.es = dec_out_sbit; o.eb = dec_out_dbit;
                obs_q.push_back(o);
            end
            cyc++;
            if (cyc > 3000) begin tmo = 1'b1; break; end
        end
        @(negedge clk);
        dec_valid = 1'b0; dec_out_ready = 1'b1;
    endtask

    task automatic compare_stream(input string name, input bit tmo);
        checks++;
        if (tmo || obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_count: got %0d words want %0d (timeout=%0b)", name, obs_q.size(), exp_q.size(), tmo);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].ed !== exp_q[i].ed || obs_q[i].t !== exp_q[i].t ||
                obs_q[i].es !== exp_q[i].es || obs_q[i].eb !== exp_q[i].eb) begin
                failures++;
                $display("FAIL %s_word[%0d]: got data=%h tag=%h s=%b d=%b want data=%h tag=%h s=%b d=%b",
                         name, i, obs_q[i].ed, obs_q[i].t, obs_q[i].es, obs_q[i].eb,
                         exp_q[i].ed, exp_q[i].t, exp_q[i].es, exp_q[i].eb);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (enc_out_valid !== 1'b0 || dec_out_valid !== 1'b0 || enc_ready !== 1'b1 || dec_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_valids: got eov=%b dov=%b er=%b dr=%b want 0 0 1 1",
                     enc_out_valid, dec_out_valid, enc_ready, dec_ready);
        end
        checks++;
        if (sbit_cnt !== '0 || dbit_cnt !== '0 || first_dbit_vld !== 1'b0 || first_dbit_tag !== '0) begin
            failures++;
            $display("FAIL reset_counters: got s=%0d d=%0d fv=%b ft=%h want 0 0 0 00",
                     sbit_cnt, dbit_cnt, first_dbit_vld, first_dbit_tag);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_encode;
        @(negedge clk);
        enc_valid = 1'b1; enc_data = 26'h0000001;
        @(posedge clk);
        @(negedge clk);
        enc_valid = 1'b0;
        checks++;
        if (enc_out_valid !== 1'b1 || enc_out_data !== 26'h0000001 || enc_out_parity !== 6'h23) begin
            failures++;
            $display("FAIL encode_d0: got v=%b data=%h par=%h want 1 0000001 23",
                     enc_out_valid, enc_out_data, enc_out_parity);
        end
        @(negedge clk);
        checks++;
        if (enc_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL encode_drain: got v=%b want 0", enc_out_valid);
        end
    endtask

    task automatic test_dec_single;
        dec_one(26'h0, 6'h23, 8'h01);
        checks++;
        if (dec_out_valid !== 1'b1 || dec_out_data !== 26'h0000001 || dec_out_sbit !== 1'b1 || dec_out_dbit !== 1'b0) begin
            failures++;
            $display("FAIL dec_single: got v=%b data=%h s=%b d=%b want 1 0000001 1 0",
                     dec_out_valid, dec_out_data, dec_out_sbit, dec_out_dbit);
        end
        @(negedge clk);
        checks++;
        if (sbit_cnt !== 2'd1) begin
            failures++;
            $display("FAIL dec_single_cnt: got %0d want 1", sbit_cnt);
        end
    endtask

    task automatic test_dec_check;
        dec_one(26'h0, 6'h20, 8'h02);
        checks++;
        if (dec_out_data !== 26'h0 || dec_out_sbit !== 1'b1 || dec_out_dbit !== 1'b0) begin
            failures++;
            $display("FAIL dec_check: got data=%h s=%b d=%b want 0000000 1 0", dec_out_data, dec_out_sbit, dec_out_dbit);
        end
        @(negedge clk);
        checks++;
        if (sbit_cnt !== 2'd2) begin
            failures++;
            $display("FAIL dec_check_cnt: got %0d want 2", sbit_cnt);
        end
    endtask

    task automatic test_dec_double;
        dec_one(26'h0000003, 6'h00, 8'h5A);
        checks++;
        if (dec_out_data !== 26'h0000003 || dec_out_sbit !== 1'b0 || dec_out_dbit !== 1'b1) begin
            failures++;
            $display("FAIL dec_double: got data=%h s=%b d=%b want 0000003 0 1", dec_out_data, dec_out_sbit, dec_out_dbit);
        end
        @(negedge clk);
        checks++;
        if (first_dbit_vld !== 1'b1 || first_dbit_tag !== 8'h5A || dbit_cnt !== 2'd1) begin
            failures++;
            $display("FAIL dec_double_capture: got fv=%b ft=%h dc=%0d want 1 5a 1", first_dbit_vld, first_dbit_tag, dbit_cnt);
        end
        dec_one(26'h0000003, 6'h00, 8'h11);
        @(negedge clk);
        checks++;
        if (first_dbit_vld !== 1'b1 || first_dbit_tag !== 8'h5A || dbit_cnt !== 2'd2) begin
            failures++;
            $display("FAIL dec_double_keep: got fv=%b ft=%h dc=%0d want 1 5a 2", first_dbit_vld, first_dbit_tag, dbit_cnt);
        end
    endtask

    task automatic test_backpressure;
        int stalls;
        bit tmo;
        int kinds[6] = '{0, 1, 2, 3, 1, 0};
        exp_q.delete();
        foreach (kinds[i]) begin
            word_t w = make_word(kinds[i], 1'b0);
            in_q.push_back(w); exp_q.push_back(w);
        end
        stream(1, stalls, tmo);
        checks++;
        if (stalls == 0) begin
            failures++;
            $display("FAIL backpressure_stall: got %0d stalled cycles want >0", stalls);
        end
        compare_stream("backpressure", tmo);
    endtask

    task automatic test_sat_clear;
        int stalls;
        bit tmo;
        int kinds[6] = '{1, 2, 3, 1, 2, 1};
        pulse_clr();
        exp_q.delete();
        foreach (kinds[i]) begin
            word_t w = make_word(kinds[i], 1'b0);
            in_q.push_back(w); exp_q.push_back(w);
        end
        stream(0, stalls, tmo);
        checks++;
        if (sbit_cnt !== 2'd3 || dbit_cnt !== 2'd1 || first_dbit_vld !== 1'b1) begin
            failures++;
            $display("FAIL saturate: got s=%0d d=%0d fv=%b want 3 1 1", sbit_cnt, dbit_cnt, first_dbit_vld);
        end
        dec_one(26'h0, 6'h23, 8'h33);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        checks++;
        if (sbit_cnt !== 2'd1 || dbit_cnt !== 2'd0 || first_dbit_vld !== 1'b0) begin
            failures++;
            $display("FAIL clear_coincident: got s=%0d d=%0d fv=%b want 1 0 0", sbit_cnt, dbit_cnt, first_dbit_vld);
        end
    endtask

    task automatic test_injection;
        logic [DW-1:0] d, d2;
        logic [DW-1:0] got_d;
        logic [PW-1:0] got_p;
        d = DW'($urandom);
        @(negedge clk);
        inject_arm = 1'b1; inject_mask = 32'h1 << PW;
        @(negedge clk);
        inject_arm = 1'b0; enc_valid = 1'b1; enc_data = d;
        @(negedge clk);
        enc_valid = 1'b0;
        got_d = enc_out_data; got_p = enc_out_parity;
        checks++;
        if (got_d !== (d ^ 26'h1) || got_p !== tb_parity(d)) begin
            failures++;
            $display("FAIL inject_enc: got data=%h par=%h want %h %h", got_d, got_p, d ^ 26'h1, tb_parity(d));
        end
        dec_one(got_d, got_p, 8'h77);
        checks++;
        if (dec_out_data !== d || dec_out_sbit !== 1'b1 || dec_out_dbit !== 1'b0) begin
            failures++;
            $display("FAIL inject_loopback: got data=%h s=%b d=%b want %h 1 0", dec_out_data, dec_out_sbit, dec_out_dbit, d);
        end
        // arm coincident with an accept: this word clean, the following one hit on check bit 2
        d = DW'($urandom); d2 = DW'($urandom);
        @(negedge clk);
        enc_valid = 1'b1; enc_data = d; inject_arm = 1'b1; inject_mask = 32'h4;
        @(negedge clk);
        inject_arm = 1'b0; enc_data = d2;
        checks++;
        if (enc_out_data !== d || enc_out_parity !== tb_parity(d)) begin
            failures++;
            $display("FAIL inject_clean_after: got data=%h par=%h want %h %h", enc_out_data, enc_out_parity, d, tb_parity(d));
        end
        @(negedge clk);
        enc_valid = 1'b0;
        checks++;
        if (enc_out_data !== d2 || enc_out_parity !== (tb_parity(d2) ^ 6'h04)) begin
            failures++;
            $display("FAIL inject_same_cycle_arm: got data=%h par=%h want %h %h",
                     enc_out_data, enc_out_parity, d2, tb_parity(d2) ^ 6'h04);
        end
        @(negedge clk);
    endtask

    task automatic test_enc_random;
        logic [DW+PW-1:0] eq[$];
        logic [DW+PW-1:0] e;
        logic [DW-1:0] d = '0;
        bit pend = 1'b0;
        int sent = 0, got = 0, cyc = 0;
        while (got < 16 && cyc < 2000) begin
            @(negedge clk);
            if (!pend && sent < 16) begin d = DW'($urandom); pend = 1'b1; end
            enc_valid = pend; enc_data = d;
            enc_out_ready = ($urandom_range(2, 0) != 0);
            #1;
            if (enc_valid && enc_ready) begin eq.push_back({d, tb_parity(d)}); pend = 1'b0; sent++; end
            if (enc_out_valid && enc_out_ready) begin
                e = (eq.size() > 0) ? eq.pop_front() : 'x;
                checks++;
                if ({enc_out_data, enc_out_parity} !== e) begin
                    failures++;
                    $display("FAIL enc_random[%0d]: got %h/%h want %h/%h", got, enc_out_data, enc_out_parity,
                             e[DW+PW-1:PW], e[PW-1:0]);
                end
                got++;
            end
            cyc++;
        end
        @(negedge clk);
        enc_valid = 1'b0; enc_out_ready = 1'b1;
        checks++;
        if (got != 16) begin
            failures++;
            $display("FAIL enc_random_count: got %0d want 16", got);
        end
    endtask

    task automatic test_random;
        int stalls, sc = 0, dc = 0;
        bit tmo, fv = 1'b0;
        logic [TW-1:0] ft = '0;
        pulse_clr();
        exp_q.delete();
        for (int i = 0; i < 60; i++) begin
            word_t w = make_word($urandom_range(3, 0), 1'b0);
            in_q.push_back(w); exp_q.push_back(w);
            if (w.es) sc = (sc < 3) ? sc + 1 : 3;
            if (w.eb) begin
                dc = (dc < 3) ? dc + 1 : 3;
                if (!fv) begin fv = 1'b1; ft = w.t; end
            end
        end
        stream(2, stalls, tmo);
        compare_stream("random", tmo);
        checks++;
        if (sbit_cnt !== CW'(sc) || dbit_cnt !== CW'(dc) || first_dbit_vld !== fv || (fv && first_dbit_tag !== ft)) begin
            failures++;
            $display("FAIL random_counters: got s=%0d d=%0d fv=%b ft=%h want %0d %0d %b %h",
                     sbit_cnt, dbit_cnt, first_dbit_vld, first_dbit_tag, sc, dc, fv, ft);
        end
    endtask

    task automatic test_bypass;
        int stalls;
        bit tmo;
        pulse_clr();
        bypass = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            word_t w = make_word(i % 4, 1'b1);
            in_q.push_back(w); exp_q.push_back(w);
        end
        stream(0, stalls, tmo);
        compare_stream("bypass", tmo);
        checks++;
        if (sbit_cnt !== '0 || dbit_cnt !== '0 || first_dbit_vld !== 1'b0) begin
            failures++;
            $display("FAIL bypass_frozen: got s=%0d d=%0d fv=%b want 0 0 0", sbit_cnt, dbit_cnt, first_dbit_vld);
        end
        bypass = 1'b0;
    endtask

    task automatic test_reset_midstream;
        @(negedge clk);
        dec_out_ready = 1'b0; enc_out_ready = 1'b0;
        dec_valid = 1'b1; dec_data = 26'h0; dec_parity = 6'h23; dec_tag = 8'h99;
        enc_valid = 1'b1; enc_data = 26'h123;
        repeat (2) @(negedge clk);
        checks++;
        if (dec_out_valid !== 1'b1 || enc_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_valid: got dov=%b eov=%b want 1 1", dec_out_valid, enc_out_valid);
        end
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dec_out_valid !== 1'b0 || enc_out_valid !== 1'b0 || sbit_cnt !== '0) begin
            failures++;
            $display("FAIL reset_mid: got dov=%b eov=%b s=%0d want 0 0 0", dec_out_valid, enc_out_valid, sbit_cnt);
        end
        dec_valid = 1'b0; enc_valid = 1'b0; dec_out_ready = 1'b1; enc_out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dec_out_valid !== 1'b0 || enc_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_discard: got dov=%b eov=%b want 0 0", dec_out_valid, enc_out_valid);
        end
    endtask

    initial begin
        build_cols();
        rst_n = 1'b0;
        enc_valid = 1'b0; enc_data = '0; enc_out_ready = 1'b1;
        inject_arm = 1'b0; inject_mask = '0;
        dec_valid = 1'b0; dec_data = '0; dec_parity = '0; dec_tag = '0; dec_out_ready = 1'b1;
        bypass = 1'b0; cnt_clr = 1'b0;
        test_reset();
        test_encode();
        test_dec_single();
        test_dec_check();
        test_dec_double();
        test_backpressure();
        test_sat_clear();
        test_injection();
        test_enc_random();
        test_random();
        test_bypass();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
